// File: rtl/tank_pkg.sv
// Shared tank-game types: shell FSM states, screen limits and fixed-point format.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tank_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLIGHT = 2'd1,
    IMPACT = 2'd2
  } shell_state_e;

  // Last visible pixel column / row.
  localparam logic [9:0] SCREEN_X_MAX = 10'd639;
  localparam logic [9:0] SCREEN_Y_MAX = 10'd479;

  // Fractional bits of the Q.4 position/velocity format.
  localparam int FRAC = 4;

endpackage

// File: rtl/terrain_height.sv
// Ground profile: maps a pixel column to the terrain surface row.
// Latency: combinational.
// Backpressure: none.
module terrain_height (
  input  logic [9:0] x,
  output logic [9:0] y
);

  logic [31:0] xw;
  logic [31:0] sq_term;
  logic [31:0] lin_term;

  // Parabolic profile with truncating divisions; the +222 offset keeps the
  // result positive over the visible columns, so unsigned arithmetic is safe.
  always_comb begin
    xw       = {22'd0, x};
    sq_term  = (32'd607 * xw * xw) / 32'd1562500;
    lin_term = (32'd71 * xw) / 32'd500;
  end

  assign y = 10'(sq_term - lin_term + 32'd222);

endmodule

// File: rtl/shell_projectile.sv
// Ballistic shell: launches on a shoot rising edge, integrates Q.4 motion with gravity per frame.
// Latency: shell appears one frame after fire is sampled; first motion the frame after.
// Backpressure: none; fire outside IDLE is dropped, never queued.
module shell_projectile
  import tank_pkg::*;
#(
  parameter int LAUNCH_VY      = 48,
  parameter int X_SPEED        = 32,
  parameter int GRAVITY        = 2,
  parameter int MUZZLE_OFFSET  = 8,
  parameter int HIT_R          = 8,
  parameter int EXPLODE_FRAMES = 16
) (
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       shoot,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [1:0] Direction,
  input  logic [9:0] y_component,
  input  logic [9:0] TargetX,
  input  logic [9:0] TargetY,
  output logic [9:0] ShellX,
  output logic [9:0] ShellY,
  output logic       ShellActive,
  output logic       ShellVisible,
  output logic       ExplodeActive,
  output logic [9:0] ExplodeX,
  output logic [9:0] ExplodeY,
  output logic       Hit,
  output logic [3:0] HitCount
);

  localparam int CW = $clog2(EXPLODE_FRAMES + 1);
  localparam logic signed [11:0] VX_MAG   = 12'(X_SPEED);
  localparam logic signed [11:0] VY_BASE  = 12'(LAUNCH_VY);
  localparam logic signed [11:0] VY_GRAV  = 12'(GRAVITY);
  localparam logic signed [10:0] MUZZLE   = 11'(MUZZLE_OFFSET);
  localparam logic signed [11:0] HIT_LIM  = 12'(HIT_R);
  localparam logic [CW-1:0]      CNT_LOAD = CW'(EXPLODE_FRAMES - 1);

  shell_state_e state;
  logic shoot_d;
  logic fire;
  logic signed [14:0] x, y, nx, ny, x_launch, y_launch;
  logic signed [11:0] vx, vy, vx_launch, vy_launch;
  logic signed [10:0] muzzle_y;
  logic signed [11:0] dx, dy;
  logic [CW-1:0] cnt;
  logic [9:0] nx_px, ny_px, ground_y, boom_y;
  logic off_screen, on_target, on_ground, in_flight;
  logic unused_dir;

  // Only bit 0 of Direction carries meaning.
  assign unused_dir = Direction[1];

  assign fire = shoot & ~shoot_d;

  terrain_height u_terrain (
    .x (nx_px),
    .y (ground_y)
  );

  // Launch point/velocity from the firing tank, and the candidate next position with its checks.
  always_comb begin
    muzzle_y  = $signed({1'b0, TankY}) - MUZZLE;
    x_launch  = $signed({1'b0, TankX, {FRAC{1'b0}}});
    y_launch  = {muzzle_y, {FRAC{1'b0}}};
    vx_launch = Direction[0] ? VX_MAG : -VX_MAG;
    vy_launch = -(VY_BASE + $signed({{2{y_component[9]}}, y_component}));

    nx    = x + {{3{vx[11]}}, vx};
    ny    = y + {{3{vy[11]}}, vy};
    nx_px = nx[FRAC+9:FRAC];
    ny_px = ny[FRAC+9:FRAC];

    off_screen = nx[14] || (nx_px > SCREEN_X_MAX) || (!ny[14] && (ny_px > SCREEN_Y_MAX));

    // Pixel distances to the target; ny may be above the screen so keep its sign.
    dx = $signed({2'b00, nx_px}) - $signed({2'b00, TargetX});
    dy = $signed({ny[14], ny[14:FRAC]}) - $signed({2'b00, TargetY});
    on_target = (dx <= HIT_LIM) && (dx >= -HIT_LIM) && (dy <= HIT_LIM) && (dy >= -HIT_LIM);

    on_ground = !ny[14] && (ny_px >= ground_y);

    // Explosion row is kept on screen.
    if (ny[14])                    boom_y = 10'd0;
    else if (ny_px > SCREEN_Y_MAX) boom_y = SCREEN_Y_MAX;
    else                           boom_y = ny_px;
  end

  // Shell FSM: launch, per-frame integration with miss/hit/ground checks, timed explosion.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      shoot_d  <= 1'b0;
      x        <= '0;
      y        <= '0;
      vx       <= '0;
      vy       <= '0;
      cnt      <= '0;
      ExplodeX <= '0;
      ExplodeY <= '0;
      Hit      <= 1'b0;
      HitCount <= '0;
    end else begin
      shoot_d <= shoot;
      Hit     <= 1'b0;
      case (state)
        IDLE: begin
          if (fire) begin
            x     <= x_launch;
            y     <= y_launch;
            vx    <= vx_launch;
            vy    <= vy_launch;
            state <= FLIGHT;
          end
        end
        FLIGHT: begin
          vy <= vy + VY_GRAV;
          if (off_screen) begin
            state <= IDLE;
          end else if (on_target || on_ground) begin
            state    <= IMPACT;
            ExplodeX <= nx_px;
            ExplodeY <= boom_y;
            cnt      <= CNT_LOAD;
            if (on_target) begin
              Hit <= 1'b1;
              if (HitCount != 4'd15) HitCount <= HitCount + 4'd1;
            end
          end else begin
            x <= nx;
            y <= ny;
          end
        end
        IMPACT: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shell outputs decode straight from registered state.
  assign in_flight     = (state == FLIGHT);
  assign ShellActive   = in_flight;
  assign ShellVisible  = in_flight && !y[14];
  assign ShellX        = in_flight ? x[FRAC+9:FRAC] : 10'd0;
  assign ShellY        = ShellVisible ? y[FRAC+9:FRAC] : 10'd0;
  assign ExplodeActive = (state == IMPACT);

endmodule

// File: tb/tb_shell_projectile.sv
`timescale 1ns/1ps
module tb_shell_projectile;

  logic       Reset, frame_clk, shoot;
  logic [9:0] TankX, TankY, y_component, TargetX, TargetY;
  logic [1:0] Direction;
  logic [9:0] ShellX, ShellY, ExplodeX, ExplodeY;
  logic       ShellActive, ShellVisible, ExplodeActive, Hit;
  logic [3:0] HitCount;

  shell_projectile dut (
    .Reset(Reset), .frame_clk(frame_clk), .shoot(shoot),
    .TankX(TankX), .TankY(TankY), .Direction(Direction), .y_component(y_component),
    .TargetX(TargetX), .TargetY(TargetY),
    .ShellX(ShellX), .ShellY(ShellY), .ShellActive(ShellActive), .ShellVisible(ShellVisible),
    .ExplodeActive(ExplodeActive), .ExplodeX(ExplodeX), .ExplodeY(ExplodeY),
    .Hit(Hit), .HitCount(HitCount)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct packed {
    logic [9:0] sx;
    logic [9:0] sy;
    logic       act;
    logic       vis;
    logic       exa;
    logic [9:0] ex;
    logic [9:0] ey;
    logic       hit;
    logic [3:0] hc;
  } obs_t;

  obs_t exp_q[$];
  int errors = 0;
  int checks = 0;

  // Behavioural game model: positions in sixteenths of a pixel, plain integers.
  int m_mode;       // 0 waiting, 1 shell flying, 2 exploding
  int m_x, m_y, m_vx, m_vy;
  int m_left;       // explosion frames still to show, including the current one
  int m_hits, m_ex, m_ey;
  bit m_prev, m_hit;

  function automatic int floor16(int q);
    if (q >= 0) return q / 16;
    return -((-q + 15) / 16);
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int terrain(int px);
    longint p;
    p = px;
    return int'((longint'(607) * p * p) / 1562500 - (71 * p) / 500 + 222);
  endfunction

  function automatic void m_reset();
    m_mode = 0; m_x = 0; m_y = 0; m_vx = 0; m_vy = 0; m_left = 0;
    m_hits = 0; m_ex = 0; m_ey = 0; m_prev = 0; m_hit = 0;
  endfunction

  function automatic void start_boom(int px, int py);
    m_mode = 2;
    m_left = 16;
    m_ex   = px;
    m_ey   = (py < 0) ? 0 : ((py > 479) ? 479 : py);
  endfunction

  // One frame of game rules applied to the inputs presented at this edge.
  function automatic void model_edge();
    int nx, ny, npx, npy, tgx, tgy;
    bit fire;
    if (Reset) begin
      m_reset();
      return;
    end
    m_hit  = 0;
    fire   = shoot && !m_prev;
    m_prev = shoot;
    tgx = int'(TargetX);
    tgy = int'(TargetY);
    case (m_mode)
      0: if (fire) begin
        m_x    = int'(TankX) * 16;
        m_y    = (int'(TankY) - 8) * 16;
        m_vx   = Direction[0] ? 32 : -32;
        m_vy   = -(48 + int'($signed(y_component)));
        m_mode = 1;
      end
      1: begin
        nx  = m_x + m_vx;
        ny  = m_y + m_vy;
        m_vy = m_vy + 2;
        npx = floor16(nx);
        npy = floor16(ny);
        if (npx < 0 || npx > 639 || npy > 479) begin
          m_mode = 0;
        end else if (iabs(npx - tgx) <= 8 && iabs(npy - tgy) <= 8) begin
          start_boom(npx, npy);
          m_hit = 1;
          if (m_hits < 15) m_hits++;
        end else if (npy >= terrain(npx)) begin
          start_boom(npx, npy);
        end else begin
          m_x = nx;
          m_y = ny;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) m_mode = 0;
      end
    endcase
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.act = (m_mode == 1);
    o.vis = (m_mode == 1) && (m_y >= 0);
    o.sx  = o.act ? 10'(floor16(m_x)) : 10'd0;
    o.sy  = o.vis ? 10'(floor16(m_y)) : 10'd0;
    o.exa = (m_mode == 2);
    o.ex  = 10'(m_ex);
    o.ey  = 10'(m_ey);
    o.hit = m_hit;
    o.hc  = 4'(m_hits);
    return o;
  endfunction

  // Monitor: compare every frame's DUT outputs against the queued expectation.
  initial begin
    obs_t e, g;
    forever begin
      @(posedge frame_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {ShellX, ShellY, ShellActive, ShellVisible, ExplodeActive, ExplodeX, ExplodeY, Hit, HitCount};
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL frame_outputs t=%0t got sx=%0d sy=%0d act=%0b vis=%0b exa=%0b ex=%0d ey=%0d hit=%0b hc=%0d want sx=%0d sy=%0d act=%0b vis=%0b exa=%0b ex=%0d ey=%0d hit=%0b hc=%0d",
                   $time, g.sx, g.sy, g.act, g.vis, g.exa, g.ex, g.ey, g.hit, g.hc,
                   e.sx, e.sy, e.act, e.vis, e.exa, e.ex, e.ey, e.hit, e.hc);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, want, $time);
    end
  endtask

  // Present shoot for the next edge, queue the model's expectation, return 2 time units after the edge.
  task automatic frame(input bit sh);
    shoot = sh;
    model_edge();
    exp_q.push_back(model_obs());
    @(posedge frame_clk);
    #2;
  endtask

  task automatic run_to_idle(input int max_frames);
    int n;
    n = 0;
    while (m_mode != 0 && n < max_frames) begin
      frame(1'b0);
      n++;
    end
    chk("idle_reached", int'(ShellActive | ExplodeActive), 0);
  endtask

  task automatic set_tank(input int tx, input int ty, input bit dir, input int yc);
    TankX = 10'(tx); TankY = 10'(ty); Direction = {1'b0, dir}; y_component = 10'(yc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int launches, booms, fly_in_boom, t;
    bit prev_act;

    Reset = 1'b1; shoot = 1'b0;
    set_tank(140, 210, 1'b1, 0);
    TargetX = 10'd600; TargetY = 10'd20;
    m_reset();
    #1;
    chk("reset_active", int'(ShellActive), 0);
    chk("reset_explode", int'(ExplodeActive), 0);
    chk("reset_hitcount", int'(HitCount), 0);
    frame(1'b0); frame(1'b0);
    Reset = 1'b0;
    frame(1'b0); frame(1'b0);

    // Launch and held fire.
    frame(1'b1);
    chk("launch_active", int'(ShellActive), 1);
    chk("launch_x", int'(ShellX), 140);
    chk("launch_y", int'(ShellY), 202);
    frame(1'b1);
    chk("first_move_x", int'(ShellX), 142);
    chk("first_move_y", int'(ShellY), 199);
    launches = 1; prev_act = 1'b1;
    for (int i = 0; i < 200; i++) begin
      frame(1'b1);
      if (ShellActive && !prev_act) launches++;
      prev_act = ShellActive;
    end
    chk("held_fire_launches", launches, 1);
    frame(1'b0);
    frame(1'b1);
    chk("relaunch_active", int'(ShellActive), 1);
    run_to_idle(300);

    // Target hit at the first flight frame, fire attempts during the explosion.
    TargetX = 10'd150; TargetY = 10'd200;
    frame(1'b0);
    frame(1'b1);
    frame(1'b0);
    chk("hit_pulse", int'(Hit), 1);
    chk("hit_count", int'(HitCount), 1);
    chk("hit_explode_x", int'(ExplodeX), 142);
    chk("hit_explode_y", int'(ExplodeY), 199);
    booms = int'(ExplodeActive); fly_in_boom = 0;
    for (int i = 0; i < 30; i++) begin
      frame(ExplodeActive ? bit'(i % 2) : 1'b0);
      if (ExplodeActive) booms++;
      if (ShellActive && booms < 16) fly_in_boom++;
    end
    chk("explode_frames", booms, 16);
    chk("fire_in_impact", fly_in_boom, 0);
    run_to_idle(100);

    // Off-screen miss on the right edge.
    TargetX = 10'd600; TargetY = 10'd20;
    set_tank(636, 250, 1'b1, 0);
    frame(1'b0);
    frame(1'b1);
    chk("miss_launch_x", int'(ShellX), 636);
    frame(1'b0);
    chk("miss_frame1_active", int'(ShellActive), 1);
    chk("miss_frame1_x", int'(ShellX), 638);
    frame(1'b0);
    chk("miss_gone", int'(ShellActive), 0);
    chk("miss_no_explode", int'(ExplodeActive), 0);
    chk("miss_no_hit", int'(HitCount), 1);

    // Terrain impact, dropped with zero vertical speed.
    set_tank(400, 232, 1'b0, -48);
    frame(1'b0);
    frame(1'b1);
    for (int i = 0; i < 40 && !ExplodeActive; i++) frame(1'b0);
    chk("ground_explode", int'(ExplodeActive), 1);
    t = terrain(int'(ExplodeX));
    chk("ground_near_surface", int'(int'(ExplodeY) >= t && int'(ExplodeY) <= t + 1), 1);
    chk("ground_x", int'(ExplodeX), 388);
    chk("ground_y", int'(ExplodeY), 225);
    run_to_idle(40);

    // Asynchronous reset mid-flight.
    set_tank(140, 210, 1'b1, 0);
    frame(1'b0);
    frame(1'b1);
    for (int i = 0; i < 4; i++) frame(1'b0);
    #1 Reset = 1'b1;
    #1;
    chk("arst_active", int'(ShellActive), 0);
    chk("arst_shell_x", int'(ShellX), 0);
    chk("arst_shell_y", int'(ShellY), 0);
    chk("arst_hitcount", int'(HitCount), 0);
    chk("arst_explode_x", int'(ExplodeX), 0);
    m_reset();
    frame(1'b0); frame(1'b0);
    Reset = 1'b0;
    frame(1'b0);
    frame(1'b1);
    chk("post_reset_active", int'(ShellActive), 1);
    chk("post_reset_x", int'(ShellX), 140);
    chk("post_reset_y", int'(ShellY), 202);
    run_to_idle(300);

    // Randomised play against the model.
    for (int i = 0; i < 600; i++) begin
      if (m_mode == 0 && $urandom_range(0, 3) == 0)
        set_tank($urandom_range(0, 639), $urandom_range(60, 470), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 148)) - 48);
      if ($urandom_range(0, 7) == 0) begin
        TargetX = 10'($urandom_range(0, 639));
        TargetY = 10'($urandom_range(0, 479));
      end
      frame($urandom_range(0, 2) == 0 ? ~shoot : shoot);
    end
    run_to_idle(400);

    // Repeated hits saturate the counter.
    set_tank(140, 210, 1'b1, 0);
    TargetX = 10'd150; TargetY = 10'd200;
    for (int i = 0; i < 16; i++) begin
      frame(1'b0);
      frame(1'b1);
      run_to_idle(40);
    end
    chk("hitcount_saturated", int'(HitCount), 15);

    frame(1'b0);
    frame(1'b0);
    repeat (3) @(posedge frame_clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
